// File: rtl/dram_pkg.sv
// Shared constants, FSM states and Wishbone command encodings for the line buffer.
package dram_pkg;

  localparam int unsigned LINE_BYTES  = 32;
  localparam int unsigned OFFSET_BITS = 5;
  localparam int unsigned TAG_BITS    = 32 - OFFSET_BITS;
  localparam int unsigned IDX_BITS    = OFFSET_BITS - 2;

  typedef enum logic [2:0] {
    StIdle,
    StWb,
    StFill,
    StAck,
    StFlushDone
  } state_e;

  // Master-side command bundle {cyc, stb, we}.
  typedef struct packed {
    logic cyc;
    logic stb;
    logic we;
  } wb_cmd_t;

  localparam wb_cmd_t WB_CMD_NONE  = '{cyc: 1'b0, stb: 1'b0, we: 1'b0};
  localparam wb_cmd_t WB_CMD_READ  = '{cyc: 1'b1, stb: 1'b1, we: 1'b0};
  localparam wb_cmd_t WB_CMD_WRITE = '{cyc: 1'b1, stb: 1'b1, we: 1'b1};

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [31:0] addr);
    return addr[31:OFFSET_BITS];
  endfunction

  function automatic logic [IDX_BITS-1:0] word_index(input logic [31:0] addr);
    return addr[OFFSET_BITS-1:2];
  endfunction

endpackage

// File: rtl/line_store.sv
// Single cache line storage: whole-line load from DRAM, byte-enable word merge, word select.
module line_store
  import dram_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = 256,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    load,
  input  logic [WORD_SIZE-1:0]    load_data,
  input  logic                    wr_en,
  input  logic [IDX_BITS-1:0]     idx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] sel,
  output logic [WORD_SIZE-1:0]    line,
  output logic [DATA_WIDTH-1:0]   rd_word
);

  logic [WORD_SIZE-1:0] line_q;
  logic [WORD_SIZE-1:0] base;
  logic [WORD_SIZE-1:0] merged;

  // A load and a write in the same cycle merge the write over the freshly loaded line.
  always_comb begin
    base   = load ? load_data : line_q;
    merged = base;
    if (wr_en) begin
      for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
        if (sel[b]) begin
          merged[int'(idx) * DATA_WIDTH + b * 8 +: 8] = wdata[b * 8 +: 8];
        end
      end
    end
    rd_word = base[int'(idx) * DATA_WIDTH +: DATA_WIDTH];
  end

  // Line contents are deliberately not reset; they are meaningless until the first fill.
  always_ff @(posedge clk) begin
    if (load || wr_en) begin
      line_q <= merged;
    end
  end

  assign line = line_q;

endmodule

// File: rtl/wb_line_buffer.sv
// One-line write-back buffer between a 32-bit Wishbone slave port and a wide DRAM master port.
module wb_line_buffer
  import dram_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = 256,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    user_clk_i,
  input  logic                    rst_n_i,
  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic                    we_i,
  input  logic [31:0]             addr_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    ack_o,
  output logic                    m_cyc_o,
  output logic                    m_stb_o,
  output logic                    m_we_o,
  output logic [31:0]             m_addr_o,
  output logic [WORD_SIZE-1:0]    m_data_o,
  input  logic [WORD_SIZE-1:0]    m_data_i,
  input  logic                    m_ack_i,
  input  logic                    flush_i,
  output logic                    flush_done_o
);

  state_e                state_q, state_d;
  logic [TAG_BITS-1:0]   tag_q, tag_d;
  logic                  valid_q, valid_d;
  logic                  dirty_q, dirty_d;
  logic                  flush_q, flush_d;
  logic                  gap_q, gap_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  req;
  logic                  hit;
  logic                  ls_load;
  logic                  ls_wr;
  logic [WORD_SIZE-1:0]  line;
  logic [DATA_WIDTH-1:0] rd_word;
  wb_cmd_t               cmd;
  logic [31:0]           m_addr;
  logic                  unused_addr_bits;

  assign req              = cyc_i & stb_i;
  assign hit              = valid_q && (tag_q == addr_tag(addr_i));
  assign unused_addr_bits = ^addr_i[1:0];

  line_store #(
    .WORD_SIZE (WORD_SIZE),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_line_store (
    .clk      (user_clk_i),
    .load     (ls_load),
    .load_data(m_data_i),
    .wr_en    (ls_wr),
    .idx      (word_index(addr_i)),
    .wdata    (data_i),
    .sel      (sel_i),
    .line     (line),
    .rd_word  (rd_word)
  );

  // Next-state, line bookkeeping and master-port command decode.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    flush_d = flush_q;
    gap_d   = 1'b0;
    data_d  = data_q;
    ls_load = 1'b0;
    ls_wr   = 1'b0;
    cmd     = WB_CMD_NONE;
    m_addr  = '0;
    unique case (state_q)
      StIdle: begin
        if (flush_i) begin
          flush_d = 1'b1;
          state_d = dirty_q ? StWb : StFlushDone;
        end else if (req) begin
          if (hit) begin
            if (we_i) begin
              ls_wr = 1'b1;
              if (sel_i != '0) dirty_d = 1'b1;
            end else begin
              data_d = rd_word;
            end
            state_d = StAck;
          end else begin
            state_d = dirty_q ? StWb : StFill;
          end
        end
      end
      StWb: begin
        cmd    = WB_CMD_WRITE;
        m_addr = {tag_q, {OFFSET_BITS{1'b0}}};
        if (m_ack_i) begin
          dirty_d = 1'b0;
          gap_d   = 1'b1;
          state_d = flush_q ? StFlushDone : StFill;
        end
      end
      StFill: begin
        // The first fill cycle after a write-back keeps the bus idle.
        if (!gap_q) begin
          cmd    = WB_CMD_READ;
          m_addr = {addr_tag(addr_i), {OFFSET_BITS{1'b0}}};
          if (m_ack_i) begin
            ls_load = 1'b1;
            tag_d   = addr_tag(addr_i);
            valid_d = 1'b1;
            dirty_d = we_i && (sel_i != '0);
            if (we_i) begin
              ls_wr = 1'b1;
            end else begin
              data_d = rd_word;
            end
            state_d = StAck;
          end
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      StFlushDone: begin
        flush_d = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control state and line metadata, cleared asynchronously.
  always_ff @(posedge user_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      tag_q   <= '0;
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
      flush_q <= 1'b0;
      gap_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      flush_q <= flush_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
    end
  end

  assign data_o       = data_q;
  assign ack_o        = (state_q == StAck);
  assign flush_done_o = (state_q == StFlushDone);
  assign m_cyc_o      = cmd.cyc;
  assign m_stb_o      = cmd.stb;
  assign m_we_o       = cmd.we;
  assign m_addr_o     = m_addr;
  assign m_data_o     = (state_q == StWb) ? line : '0;

endmodule

// File: tb/tb_wb_line_buffer.sv
// Bench for wb_line_buffer: directed vector table, multi-cycle sequences, random ops vs model.
module tb_wb_line_buffer;

  typedef struct packed {
    logic         we;
    logic [31:0]  addr;
    logic [255:0] data;
  } bus_ev_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          delay;
    logic [31:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cyc, stb, we;
  logic [31:0]  addr, wdata;
  logic [3:0]   sel;
  logic [31:0]  data_o;
  logic         ack_o;
  logic         m_cyc_o, m_stb_o, m_we_o;
  logic [31:0]  m_addr_o;
  logic [255:0] m_data_o, m_data_i;
  logic         m_ack_i;
  logic         flush, flush_done_o;

  int n_checks = 0;
  int n_errors = 0;

  // Responder state and DRAM contents.
  logic [255:0] mem [logic [31:0]];
  bit           busy;
  logic [31:0]  b_addr;
  logic         b_we;
  logic [255:0] b_data;
  int           b_wait, b_delay;
  bus_ev_t      obs_q[$];
  bus_ev_t      exp_q[$];

  // Reference model of the buffered line.
  bit           mv, md;
  logic [31:0]  mtag;
  logic [7:0]   mbytes [32];

  always #5 clk = ~clk;

  wb_line_buffer dut (
    .user_clk_i  (clk),
    .rst_n_i     (rst_n),
    .cyc_i       (cyc),
    .stb_i       (stb),
    .we_i        (we),
    .addr_i      (addr),
    .data_i      (wdata),
    .sel_i       (sel),
    .data_o      (data_o),
    .ack_o       (ack_o),
    .m_cyc_o     (m_cyc_o),
    .m_stb_o     (m_stb_o),
    .m_we_o      (m_we_o),
    .m_addr_o    (m_addr_o),
    .m_data_o    (m_data_o),
    .m_data_i    (m_data_i),
    .m_ack_i     (m_ack_i),
    .flush_i     (flush),
    .flush_done_o(flush_done_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i * 32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] mem_peek(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = rand_line();
    return mem[a];
  endfunction

  function automatic logic [255:0] pack_line();
    logic [255:0] l;
    for (int i = 0; i < 32; i++) l[i * 8 +: 8] = mbytes[i];
    return l;
  endfunction

  function automatic logic [255:0] ctrl_outputs();
    return 256'({ack_o, flush_done_o, m_cyc_o, m_stb_o, m_we_o, data_o, m_addr_o});
  endfunction

  // DRAM slave: called once per negedge; acks after b_delay waiting cycles.
  task automatic service_bus();
    bus_ev_t ev;
    if (m_ack_i) begin
      m_ack_i  = 1'b0;
      m_data_i = rand_line();
      check("bus_gap_after_ack", 32'({m_cyc_o, m_stb_o}), 32'd0);
    end else if (m_cyc_o && m_stb_o) begin
      if (!busy) begin
        busy   = 1'b1;
        b_addr = m_addr_o;
        b_we   = m_we_o;
        b_data = m_data_o;
        b_wait = 0;
      end else begin
        check("bus_addr_stable", {m_addr_o[31:1], m_we_o}, {b_addr[31:1], b_we});
        if (b_we) check_line("bus_wdata_stable", m_data_o, b_data);
      end
      if (b_wait >= b_delay) begin
        m_ack_i = 1'b1;
        if (b_we) mem[b_addr] = b_data;
        else m_data_i = mem_peek(b_addr);
        ev.we   = b_we;
        ev.addr = b_addr;
        ev.data = b_we ? b_data : '0;
        obs_q.push_back(ev);
        busy = 1'b0;
      end else begin
        b_wait++;
      end
    end else begin
      busy = 1'b0;
    end
  endtask

  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] s, output logic [31:0] rd, output bit hit);
    logic [31:0]  la;
    logic [255:0] l;
    int           off;
    bus_ev_t      ev;
    la  = a & 32'hFFFF_FFE0;
    off = int'(a[4:0]) & 28;
    hit = mv && (mtag == la);
    rd  = '0;
    if (!hit) begin
      if (mv && md) begin
        ev.we = 1'b1; ev.addr = mtag; ev.data = pack_line();
        exp_q.push_back(ev);
      end
      ev.we = 1'b0; ev.addr = la; ev.data = '0;
      exp_q.push_back(ev);
      l = mem_peek(la);
      for (int i = 0; i < 32; i++) mbytes[i] = l[i * 8 +: 8];
      mv = 1'b1; md = 1'b0; mtag = la;
    end
    for (int k = 0; k < 4; k++) begin
      if (w && s[k]) begin
        mbytes[off + k] = wd[k * 8 +: 8];
        md = 1'b1;
      end
      rd[k * 8 +: 8] = mbytes[off + k];
    end
  endtask

  task automatic model_flush();
    bus_ev_t ev;
    if (mv && md) begin
      ev.we = 1'b1; ev.addr = mtag; ev.data = pack_line();
      exp_q.push_back(ev);
      md = 1'b0;
    end
  endtask

  task automatic check_events(input string name);
    int n;
    check({name, "_bus_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({name, "_bus_addr_we"}, {obs_q[i].addr[31:1], obs_q[i].we},
            {exp_q[i].addr[31:1], exp_q[i].we});
      check_line({name, "_bus_wdata"}, obs_q[i].data, exp_q[i].data);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input int delay, output logic [31:0] rd,
                        output int cycles);
    bit got;
    b_delay = delay;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = wd; sel = s;
    got = 1'b0; cycles = 0; rd = '0;
    while (!got && cycles < 200) begin
      @(negedge clk);
      cycles++;
      service_bus();
      if (ack_o) begin
        got = 1'b1;
        rd  = data_o;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    check("ack_seen", 32'(got), 32'd1);
    @(negedge clk);
    service_bus();
    check("ack_single_pulse", 32'(ack_o), 32'd0);
  endtask

  task automatic flush_op(input int delay);
    bit seen;
    int n;
    b_delay = delay;
    flush = 1'b1; seen = 1'b0; n = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      service_bus();
      if (flush_done_o) seen = 1'b1;
    end
    flush = 1'b0;
    check("flush_done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    service_bus();
    check("flush_done_pulse", 32'(flush_done_o), 32'd0);
    model_flush();
    check_events("flush");
  endtask

  initial begin
    vec_t         vecs[10];
    logic [31:0]  rd, exp_m;
    logic [255:0] l;
    int           cyc_n, fd_cyc, ack_cyc, n;
    bit           hit;
    logic [31:0]  lines[5];

    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
    flush = 1'b0; m_ack_i = 1'b0; m_data_i = rand_line();
    busy = 1'b0; b_delay = 0; b_wait = 0; mv = 1'b0; md = 1'b0; mtag = '0;

    l = '0; l[63:32] = 32'hDEADBEEF; l[95:64] = 32'hCAFEF00D; mem[32'h100] = l;
    l = '0; l[31:0] = 32'h12345678; l[63:32] = 32'h9ABCDEF0; mem[32'h2000] = l;
    l = '0; l[31:0] = 32'h0BADF00D; mem[32'h3000] = l;

    repeat (3) @(negedge clk);
    check_line("reset_ctrl_outputs", ctrl_outputs(), '0);
    check_line("reset_m_data_o", m_data_o, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check_line("idle_ctrl_outputs", ctrl_outputs(), '0);

    vecs[0] = '{1'b0, 32'h0000_0104, 32'h0,         4'h0, 0,  32'hDEADBEEF};
    vecs[1] = '{1'b1, 32'h0000_0108, 32'h11223344, 4'h3, 0,  32'h0};
    vecs[2] = '{1'b0, 32'h0000_0108, 32'h0,         4'h0, 0,  32'hCAFE3344};
    vecs[3] = '{1'b0, 32'h0000_2000, 32'h0,         4'h0, 1,  32'h12345678};
    vecs[4] = '{1'b1, 32'h0000_2004, 32'hFFFFFFFF, 4'h0, 0,  32'h0};
    vecs[5] = '{1'b0, 32'h0000_3000, 32'h0,         4'h0, 20, 32'h0BADF00D};
    vecs[6] = '{1'b0, 32'h0000_2004, 32'h0,         4'h0, 0,  32'h9ABCDEF0};
    vecs[7] = '{1'b1, 32'h0000_2010, 32'hA5A5A5A5, 4'hF, 0,  32'h0};
    vecs[8] = '{1'b1, 32'h0000_2012, 32'h00C30000, 4'h4, 0,  32'h0};
    vecs[9] = '{1'b0, 32'h0000_2010, 32'h0,         4'h0, 0,  32'hA5C3A5A5};

    foreach (vecs[i]) begin
      model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sel, exp_m, hit);
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sel, vecs[i].delay, rd, cyc_n);
      if (!vecs[i].we) check("vec_read_data", rd, vecs[i].exp);
      if (hit) check("hit_ack_latency", 32'(cyc_n), 32'd1);
      check_events("vec");
      if (i == 3) check("wb_merged_word", mem[32'h100][95:64], 32'hCAFE3344);
    end

    // Flush with a dirty line races a read hit: write-back and flush_done come first.
    model_flush();
    model_access(1'b0, 32'h0000_2010, 32'h0, 4'h0, exp_m, hit);
    b_delay = 2;
    flush = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h0000_2010; sel = 4'h0;
    fd_cyc = 0; ack_cyc = 0; n = 0; rd = '0;
    while (ack_cyc == 0 && n < 200) begin
      @(negedge clk);
      n++;
      service_bus();
      if (flush_done_o && fd_cyc == 0) begin
        fd_cyc = n;
        flush  = 1'b0;
      end
      if (ack_o) begin
        ack_cyc = n;
        rd      = data_o;
      end
    end
    flush = 1'b0; cyc = 1'b0; stb = 1'b0;
    check("flush_race_done_seen", 32'(fd_cyc != 0), 32'd1);
    check("flush_race_ack_after_done", 32'(ack_cyc > fd_cyc), 32'd1);
    check("flush_race_read_data", rd, exp_m);
    @(negedge clk);
    service_bus();
    check_events("flush_race");
    check("flush_wb_word4", mem[32'h2000][159:128], 32'hA5C3A5A5);

    flush_op(0);

    // Reset asserted while a fill is outstanding.
    b_delay = 1000;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h0000_4000; sel = 4'h0;
    repeat (3) begin
      @(negedge clk);
      service_bus();
    end
    check("fill_outstanding", 32'({m_cyc_o, m_stb_o, m_we_o}), 32'b110);
    check("fill_addr", m_addr_o, 32'h0000_4000);
    rst_n = 1'b0;
    #1;
    check_line("midfill_reset_ctrl", ctrl_outputs(), '0);
    check_line("midfill_reset_m_data", m_data_o, '0);
    cyc = 1'b0; stb = 1'b0; busy = 1'b0; m_ack_i = 1'b0;
    obs_q.delete(); exp_q.delete();
    mv = 1'b0; md = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_access(1'b0, 32'h0000_4000, 32'h0, 4'h0, exp_m, hit);
    access(1'b0, 32'h0000_4000, 32'h0, 4'h0, 0, rd, cyc_n);
    check("refill_after_reset_data", rd, exp_m);
    check_events("refill_after_reset");

    // Random traffic across a handful of lines.
    lines[0] = 32'h0000_0100; lines[1] = 32'h0000_2000; lines[2] = 32'h0000_3000;
    lines[3] = 32'h0000_4000; lines[4] = 32'hFFFF_FFE0;
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        flush_op(int'($urandom_range(0, 3)));
      end else begin
        logic        w;
        logic [31:0] a, d;
        logic [3:0]  s;
        w = 1'($urandom_range(0, 1));
        a = lines[$urandom_range(0, 4)] | (32'($urandom_range(0, 7)) << 2)
            | 32'($urandom_range(0, 3));
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        model_access(w, a, d, s, exp_m, hit);
        access(w, a, d, s, int'($urandom_range(0, 3)), rd, cyc_n);
        if (!w) check("rand_read_data", rd, exp_m);
        if (hit) check("rand_hit_latency", 32'(cyc_n), 32'd1);
        check_events("rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_line_buffer.md
WB_LINE_BUFFER -- requirements
Module: wb_line_buffer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 256: line width in bits; equals the downstream DRAM controller word.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: CPU-side word width in bits.
REQ-003 SHALL have port user_clk_i  in  1: the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_i  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have ports cyc_i, stb_i, we_i  in  1 each: CPU-side Wishbone classic slave controls.
REQ-006 SHALL have ports addr_i  in  32 (byte address); data_i  in  32; sel_i  in  4 (byte enables).
REQ-007 SHALL have ports data_o  out  32 and ack_o  out  1.
REQ-008 SHALL have ports m_cyc_o, m_stb_o, m_we_o  out  1 each: DRAM-side Wishbone master controls.
REQ-009 SHALL have ports m_addr_o  out  32; m_data_o  out  WORD_SIZE; m_data_i  in  WORD_SIZE; m_ack_i  in  1.
REQ-010 SHALL have ports flush_i  in  1 (write-back request) and flush_done_o  out  1 (one-cycle pulse).

Function
REQ-011 SHALL hold one 32-byte line: data, tag = addr[31:5], valid bit, dirty bit; word index = addr[4:2].
REQ-012 SHALL use states IDLE, WB, FILL, ACK, FLUSH_DONE.
REQ-013 IDLE: when cyc_i&stb_i and valid and tag match (hit), SHALL perform the access and enter ACK; ack_o is high exactly one cycle after acceptance.
REQ-014 Read hit: data_o SHALL present the indexed 32-bit word, registered, valid while ack_o is high.
REQ-015 Write hit: SHALL merge only the bytes enabled by sel_i into the indexed word and set dirty; sel_i = 0 SHALL ack with no change and leave dirty unchanged.
REQ-016 Miss, line clean or invalid: SHALL go to FILL; miss with dirty line: SHALL go to WB, then FILL.
REQ-017 WB: m_cyc_o=m_stb_o=m_we_o=1, m_addr_o={stored tag,5'b0}, m_data_o=line; held stable until m_ack_i; then clear dirty.
REQ-018 FILL: m_cyc_o=m_stb_o=1, m_we_o=0, m_addr_o={addr_i[31:5],5'b0}; on m_ack_i capture m_data_i, set tag and valid, clear dirty, perform the pending access, enter ACK.
REQ-019 After every m_ack_i, m_cyc_o and m_stb_o SHALL be low for at least one cycle before the next master request.
REQ-020 ACK SHALL last exactly one cycle, then return to IDLE; a request still asserted in IDLE is treated as new.
REQ-021 flush_i in IDLE SHALL take priority over a simultaneous CPU request; if dirty, go WB then FLUSH_DONE; if clean or invalid, go FLUSH_DONE directly.
REQ-022 FLUSH_DONE SHALL pulse flush_done_o for one cycle and return to IDLE; valid stays set.
REQ-023 flush_i outside IDLE SHALL be ignored; the requester holds it until flush_done_o.
REQ-024 m_ack_i outside WB or FILL SHALL be ignored.
REQ-025 CPU inputs SHALL be held stable by the requester until ack_o; the block does not register addr_i or data_i.

Reset
REQ-026 Assertion of rst_n_i SHALL immediately force IDLE, valid=0, dirty=0, and all outputs to 0, including mid-WB or mid-FILL.
REQ-027 Line data SHALL not be reset; it is undefined until the first FILL.

Structure
REQ-028 Package dram_pkg SHALL hold LINE_BYTES=32, OFFSET_BITS=5, the state enum, and the Wishbone command bit encodings.
REQ-029 Line storage with byte-enable merge and word select SHALL be one sub-module, line_store; the FSM stays in wb_line_buffer.

Verification
REQ-030 After reset, read 0x0000_0104 -> FILL with m_addr_o=0x0000_0100 and m_we_o=0; m_data_i word 1 = 0xDEADBEEF -> data_o=0xDEADBEEF with ack_o.
REQ-031 Write 0x0000_0108 with data 0x11223344 and sel 4'b0011, then read it -> bytes [15:0]=0x3344 and upper bytes unchanged; no master cycle; ack 1 cycle after each request.
REQ-032 Dirty line tag 0x0000_0100, then read 0x0000_2000 -> WB to 0x0000_0100 carrying the merged line, a gap of at least one idle cycle, FILL from 0x0000_2000, then ack.
REQ-033 flush_i with a dirty line and a simultaneous CPU read hit -> WB first, flush_done_o pulses, then the read acks; a second flush_i -> flush_done_o with no master cycle.
REQ-034 rst_n_i low mid-FILL with m_ack_i withheld -> m_cyc_o=0 the same cycle; a following read of the same address misses and refills.
REQ-035 m_ack_i delayed 0, 1, and 20 cycles -> m_addr_o and m_data_o stay stable throughout and ack_o is a single pulse.
